// File: rtl/onchip_ram_avmm_if.sv
// onchip_ram_avmm_if: Avalon-MM command/response bundle for the on-chip RAM slave
interface onchip_ram_avmm_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic chipselect;
  logic read;
  logic write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input readdata, readdatavalid, waitrequest
  );
  modport slave (
    input address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_avmm.sv
// onchip_ram_avmm: parametrised byte-enabled RAM as a pipelined Avalon-MM slave with optional zero-clear after reset
module onchip_ram_avmm #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int READ_LATENCY = 1,
  parameter bit CLEAR_ON_RESET = 1,
  parameter string INIT_FILE = ""
) (
  input logic clk,
  input logic reset,
  input logic reset_req,
  input logic clken,
  onchip_ram_avmm_if.slave bus,
  output logic init_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  state_t state, state_nx;
  logic en, clearing, in_range, cmd, rd_acc, wr_en;
  logic [ADDR_WIDTH-1:0] clr_cnt, wr_addr;
  logic [NB-1:0] wr_be;
  logic [DATA_WIDTH-1:0] wr_data, ram_q, s2_q, pre_q;
  logic ram_v, ram_oor, s2_v, pre_v;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  if (CLEAR_ON_RESET == 0 && INIT_FILE != "") begin : g_preload
  end

  assign en = clken & ~reset_req;
  assign bus.waitrequest = reset | (state == CLEAR) | ~en;
  assign in_range = {1'b0, bus.address} < DEPTH_W;
  assign cmd = bus.chipselect & ~bus.waitrequest;
  assign rd_acc = cmd & bus.read & ~bus.write;
  assign clearing = en & ~reset & (state == CLEAR);
  assign wr_en = clearing | (cmd & bus.write & in_range);

  always_comb begin
    state_nx = (state == CLEAR && clr_cnt == LAST) ? RUN : state;
    wr_addr = clearing ? clr_cnt : bus.address;
    wr_be = clearing ? {NB{1'b1}} : bus.byteenable;
    wr_data = clearing ? '0 : bus.writedata;
    pre_v = (READ_LATENCY == 2) ? s2_v : ram_v;
    pre_q = (READ_LATENCY == 2) ? s2_q : (ram_oor ? '0 : ram_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      clr_cnt <= '0;
      init_done <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
      init_done <= state_nx == RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      ram_q <= mem[bus.address];
      ram_oor <= ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_v <= 1'b0;
      s2_v <= 1'b0;
      s2_q <= '0;
      bus.readdatavalid <= 1'b0;
      bus.readdata <= '0;
    end else begin
      bus.readdatavalid <= en & pre_v;
      if (en) begin
        ram_v <= rd_acc;
        s2_v <= ram_v;
        if (ram_v) s2_q <= ram_oor ? '0 : ram_q;
        if (pre_v) bus.readdata <= pre_q;
      end
    end
  end
endmodule
